servo_controller_top: RTL and testbench
=======================================

SERVO_CONTROLLER_TOP -- requirements
Module: servo_controller_top

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 1000000; meaning: clocks per PWM frame (20 ms at 50 MHz).
REQ-002 SHALL have parameter MIN_PULSE_CYCLES, default 50000; meaning: pulse width for duty code 0 (1 ms).
REQ-003 SHALL have parameter STEP_CYCLES, default 196; meaning: extra pulse clocks per duty LSB.
REQ-004 SHALL have port clock, input, 1 bit; the only clock, all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port load, input, 1 bit; writes switch_duty_cycle into the addressed channel.
REQ-007 SHALL have port switch_duty_cycle, input, 8 bits; unsigned duty code 0-255.
REQ-008 SHALL have port servo_address, input, 2 bits; selects channel 0-3 for both write and output.
REQ-009 SHALL have port servo_pwm_out, output, 1 bit; registered PWM of the addressed channel.

Function
REQ-010 SHALL hold four 8-bit duty registers (channels 0-3).
REQ-011 SHALL, on each rising edge with load=1, write switch_duty_cycle into register[servo_address]; level-sensitive, repeated writes idempotent.
REQ-012 SHALL run one free-running frame counter, 0 to PERIOD_CYCLES-1, then wrap to 0, shared by all channels.
REQ-013 SHALL compute pulse width W = MIN_PULSE_CYCLES + duty*STEP_CYCLES, saturated at PERIOD_CYCLES, with internal width sufficient for no overflow.
REQ-014 SHALL drive servo_pwm_out high on the clock after counter value k when k < W, low otherwise; each frame has exactly W high cycles, then PERIOD_CYCLES-W low cycles.
REQ-015 SHALL take W from the channel selected by servo_address in the current cycle; an address change affects the output one clock later without resetting the counter.
REQ-016 SHALL give W = PERIOD_CYCLES a constant-high output, with no low glitch at wrap.
REQ-017 SHALL apply simultaneous load and address change to the new address.
REQ-018 SHALL let a write to a non-addressed channel leave servo_pwm_out unaffected.

Reset
REQ-019 SHALL, while reset_n=0, force counter=0, all duty registers=0, and servo_pwm_out=0, asynchronously.
REQ-020 SHALL, after reset_n deasserts, have the first rising edge start frame 0: output high on the next edge with duty 0, giving W=MIN_PULSE_CYCLES.
REQ-021 SHALL, on reset mid-frame, abort the frame immediately and restart as in REQ-020.

Configuration
REQ-022 SHALL, with macro SERVO_SHADOW_UPDATE_EN defined, copy each duty register into a per-channel shadow register only when counter wraps to 0, with W taken from shadows so a pulse never changes mid-frame; the shadows reset to 0.
REQ-023 SHALL, without SERVO_SHADOW_UPDATE_EN, use duty registers directly, so a write takes effect on the next compare, mid-frame allowed.

Verification (PERIOD_CYCLES=400, MIN_PULSE_CYCLES=10, STEP_CYCLES=1 unless stated)
REQ-024 SHALL check: reset, then idle with address 0 -> 10 high cycles, then 390 low, repeating every 400 clocks.
REQ-025 SHALL check: address 2, load 1 cycle with duty 100, address 2 -> 110 high cycles per frame; address 0 still gives 10 high cycles.
REQ-026 SHALL check: duty 255 with STEP_CYCLES=2 -> W=520 saturates to 400 and the output is constantly high.
REQ-027 SHALL check: with the macro defined, write duty 50 at counter 5 -> current frame keeps 10 high, next frame 60 high; without the macro -> current frame goes high through counter 59.
REQ-028 SHALL check: reset_n pulsed low at counter 200 with duty 100 -> output 0 at once, registers cleared, and the next frame has 10 high cycles.
REQ-029 SHALL check: address toggled 0->1 mid-pulse with channel 1 duty 0 -> output follows the channel 1 compare one clock later.

Source files
------------

// File: rtl/servo_controller_top.sv
// Four-channel servo PWM generator sharing one frame counter; the addressed channel drives the
// output. Define SERVO_SHADOW_UPDATE_EN to latch duty codes only at frame wrap.
module servo_controller_top #(
  parameter int unsigned PERIOD_CYCLES    = 1000000,
  parameter int unsigned MIN_PULSE_CYCLES = 50000,
  parameter int unsigned STEP_CYCLES      = 196
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] switch_duty_cycle,
  input  logic [1:0] servo_address,
  output logic       servo_pwm_out
);

  localparam int unsigned CntW   = $clog2(PERIOD_CYCLES + 1);
  localparam int unsigned RawMax = MIN_PULSE_CYCLES + 255 * STEP_CYCLES;
  localparam int unsigned RawW   = $clog2(RawMax + 1);
  // Common width so the raw width and the period compare without truncation.
  localparam int unsigned CalcW  = (RawW > CntW) ? RawW : CntW;

  localparam logic [CntW-1:0]  LastCnt = CntW'(PERIOD_CYCLES - 1);
  localparam logic [CalcW-1:0] PeriodC = CalcW'(PERIOD_CYCLES);
  localparam logic [CalcW-1:0] MinC    = CalcW'(MIN_PULSE_CYCLES);
  localparam logic [CalcW-1:0] StepC   = CalcW'(STEP_CYCLES);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             wrap;
  logic [7:0]       duty_q [4];
  logic [7:0]       duty_d [4];
  logic [7:0]       sel_duty;
  logic [CalcW-1:0] raw_width;
  logic [CntW-1:0]  pulse_width;
  logic             pwm_q, pwm_d;

  assign wrap  = (cnt_q == LastCnt);
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

  always_comb begin
    duty_d = duty_q;
    if (load) begin
      duty_d[servo_address] = switch_duty_cycle;
    end
  end

`ifdef SERVO_SHADOW_UPDATE_EN
  logic [7:0] shadow_q [4];
  logic [7:0] shadow_d [4];

  always_comb begin
    shadow_d = shadow_q;
    if (wrap) begin
      shadow_d = duty_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign sel_duty = shadow_q[servo_address];
`else
  assign sel_duty = duty_q[servo_address];
`endif

  always_comb begin
    raw_width   = MinC + CalcW'(sel_duty) * StepC;
    pulse_width = (raw_width > PeriodC) ? CntW'(PeriodC) : CntW'(raw_width);
    pwm_d       = (cnt_q < pulse_width);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      duty_q <= '{default: '0};
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign servo_pwm_out = pwm_q;

endmodule

// File: tb/tb_servo_controller_top.sv
// Randomised and directed bench for servo_controller_top: two instances (STEP 1 and STEP 2)
// share stimulus and are compared against a frame-position reference model.
module tb_servo_controller_top;

  localparam int P   = 400;
  localparam int MIN = 10;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] sw;
  logic [1:0] addr;
  logic       pwm_a, pwm_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: edge count since reset and the duty codes held per channel.
  int n = 0;
  int duty [4];
  int shadow [4];
  bit exp_a, exp_b;

  servo_controller_top #(
    .PERIOD_CYCLES(P), .MIN_PULSE_CYCLES(MIN), .STEP_CYCLES(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .switch_duty_cycle(sw),
    .servo_address(addr), .servo_pwm_out(pwm_a)
  );

  servo_controller_top #(
    .PERIOD_CYCLES(P), .MIN_PULSE_CYCLES(MIN), .STEP_CYCLES(2)
  ) dut_sat (
    .clock(clock), .reset_n(reset_n), .load(load), .switch_duty_cycle(sw),
    .servo_address(addr), .servo_pwm_out(pwm_b)
  );

  always #5 clock = ~clock;

  function automatic int width(input int d, input int step);
    int w;
    w = MIN + d * step;
    return (w > P) ? P : w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      duty[i]   = 0;
      shadow[i] = 0;
    end
    n     = 0;
    exp_a = 1'b0;
    exp_b = 1'b0;
  endtask

  // One clock edge: the model computes what the output should be after it, then samples #1 later.
  task automatic tick();
    int pos;
    int eff;
    @(posedge clock);
    pos = n % P;
`ifdef SERVO_SHADOW_UPDATE_EN
    eff = shadow[addr];
    if (pos == P - 1) begin
      for (int i = 0; i < 4; i++) shadow[i] = duty[i];
    end
`else
    eff = duty[addr];
`endif
    exp_a = (pos < width(eff, 1));
    exp_b = (pos < width(eff, 2));
    if (load) duty[addr] = int'(sw);
    n++;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_clear();
    #13;
    reset_n = 1'b1;
  endtask

  task automatic align(input int k);
    while (n % P != k) tick();
  endtask

  // Runs one full frame from counter 0, counting high cycles and disagreements with the model.
  task automatic run_frame(output int ha, output int hb, output int da, output int db);
    ha = 0; hb = 0; da = 0; db = 0;
    align(0);
    for (int i = 0; i < P; i++) begin
      tick();
      ha += int'(pwm_a);
      hb += int'(pwm_b);
      if (pwm_a !== exp_a) da++;
      if (pwm_b !== exp_b) db++;
    end
  endtask

  task automatic test_reset();
    int ha, hb, da, db;
    load = 1'b0; sw = '0; addr = 2'd0; reset_n = 1'b0;
    #12;
    n_cmp++;
    if (pwm_a !== 1'b0 || pwm_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out: got %b/%b expected 0/0", pwm_a, pwm_b);
    end
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (pwm_a !== 1'b1) begin
      n_bad++;
      $display("FAIL first_edge_high: got %b expected 1", pwm_a);
    end
    for (int f = 0; f < 2; f++) begin
      run_frame(ha, hb, da, db);
      n_cmp++;
      if (ha !== 10 || da !== 0) begin
        n_bad++;
        $display("FAIL idle_frame%0d: got %0d high (%0d diffs) expected 10 high", f, ha, da);
      end
    end
  endtask

  task automatic test_write();
    int ha, hb, da, db;
    addr = 2'd2; sw = 8'd100; load = 1'b1;
    tick();
    load = 1'b0;
    run_frame(ha, hb, da, db);
    n_cmp++;
    if (ha !== 110 || da !== 0) begin
      n_bad++;
      $display("FAIL ch2_duty100: got %0d high (%0d diffs) expected 110", ha, da);
    end
    n_cmp++;
    if (hb !== 210 || db !== 0) begin
      n_bad++;
      $display("FAIL ch2_duty100_step2: got %0d high (%0d diffs) expected 210", hb, db);
    end
    addr = 2'd0;
    run_frame(ha, hb, da, db);
    n_cmp++;
    if (ha !== 10 || da !== 0) begin
      n_bad++;
      $display("FAIL ch0_after_ch2_write: got %0d high expected 10", ha);
    end
  endtask

  task automatic test_saturation();
    int ha, hb, da, db;
    int tot;
    addr = 2'd3; sw = 8'd255; load = 1'b1;
    tick();
    load = 1'b0;
    tot = 0;
    for (int f = 0; f < 2; f++) begin
      run_frame(ha, hb, da, db);
      tot += hb;
      n_cmp++;
      if (ha !== 265 || da !== 0) begin
        n_bad++;
        $display("FAIL duty255_step1: got %0d high expected 265", ha);
      end
    end
    n_cmp++;
    if (tot !== 2 * P) begin
      n_bad++;
      $display("FAIL saturated_const_high: got %0d high expected %0d", tot, 2 * P);
    end
  endtask

  task automatic test_midframe();
    int ha, hb, da, db;
    int hi;
    int want;
    do_reset();
    addr = 2'd0; load = 1'b0; sw = 8'd50;
    hi = 0;
    for (int i = 0; i < P; i++) begin
      load = (i == 5);
      tick();
      hi += int'(pwm_a);
    end
    load = 1'b0;
`ifdef SERVO_SHADOW_UPDATE_EN
    want = 10;
`else
    want = 60;
`endif
    n_cmp++;
    if (hi !== want) begin
      n_bad++;
      $display("FAIL midframe_write_current: got %0d high expected %0d", hi, want);
    end
    run_frame(ha, hb, da, db);
    n_cmp++;
    if (ha !== 60 || da !== 0) begin
      n_bad++;
      $display("FAIL midframe_write_next: got %0d high expected 60", ha);
    end
  endtask

  task automatic test_reset_mid();
    int ha, hb, da, db;
    addr = 2'd0; sw = 8'd100; load = 1'b1;
    tick();
    load = 1'b0;
    align(200);
    n_cmp++;
    if (pwm_b !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_high: got %b expected 1", pwm_b);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (pwm_a !== 1'b0 || pwm_b !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_out: got %b/%b expected 0/0", pwm_a, pwm_b);
    end
    model_clear();
    #12;
    reset_n = 1'b1;
    run_frame(ha, hb, da, db);
    n_cmp++;
    if (ha !== 10 || hb !== 10 || da !== 0 || db !== 0) begin
      n_bad++;
      $display("FAIL post_reset_frame: got %0d/%0d high expected 10/10", ha, hb);
    end
  endtask

  task automatic test_addr_toggle();
    do_reset();
    addr = 2'd1; sw = 8'd0; load = 1'b1;
    tick();
    addr = 2'd0; sw = 8'd100;
    tick();
    load = 1'b0;
    align(50);
    n_cmp++;
    if (pwm_a !== 1'b1) begin
      n_bad++;
      $display("FAIL ch0_mid_pulse: got %b expected 1", pwm_a);
    end
    addr = 2'd1;
    tick();
    n_cmp++;
    if (pwm_a !== 1'b0 || pwm_a !== exp_a) begin
      n_bad++;
      $display("FAIL addr_to_ch1: got %b expected 0", pwm_a);
    end
    addr = 2'd0;
    tick();
    n_cmp++;
    if (pwm_a !== 1'b1) begin
      n_bad++;
      $display("FAIL addr_back_ch0: got %b expected 1", pwm_a);
    end
  endtask

  task automatic test_random();
    int bad_a, bad_b;
    bad_a = 0; bad_b = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(7) == 0);
      sw   = 8'($urandom_range(255));
      if ($urandom_range(15) == 0) addr = 2'($urandom_range(3));
      tick();
      n_cmp++;
      if (pwm_a !== exp_a) begin
        n_bad++;
        if (bad_a++ < 5) $display("FAIL random_a n=%0d: got %b expected %b", n, pwm_a, exp_a);
      end
      n_cmp++;
      if (pwm_b !== exp_b) begin
        n_bad++;
        if (bad_b++ < 5) $display("FAIL random_b n=%0d: got %b expected %b", n, pwm_b, exp_b);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_saturation();
    test_midframe();
    test_reset_mid();
    test_addr_toggle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
